// File: rtl/vnu_pkg.sv
// Shared types and helpers for the serial LDPC variable node unit.
// Default degree and width are also used by the CNU array.
package vnu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EMIT = 2'd2
    } vnu_state_e;

    localparam int VNU_DV = 6;
    localparam int VNU_W  = 8;

    // Symmetric clamp to +/-(2^(w-1)-1); the most negative code is never produced.
    function automatic logic signed [31:0] sat_msg(input logic signed [31:0] value, input int w);
        logic signed [31:0] lim;
        lim = (32'sd1 <<< (w - 1)) - 32'sd1;
        if (value > lim) begin
            return lim;
        end
        if (value < -lim) begin
            return -lim;
        end
        return value;
    endfunction

endpackage

// File: rtl/vnu_msg_buf.sv
// DV x W message register file: one synchronous write port, one async read port.
// Contents are not reset; they are always rewritten before being read.
module vnu_msg_buf #(
    parameter int DV = 6,
    parameter int W  = 8,
    parameter int IW = 3
) (
    input  logic          clk,
    input  logic          we,
    input  logic [IW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [IW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem_q [DV];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/vnu_serial.sv
// Edge-serial LDPC variable node: loads L plus DV R messages, then emits DV
// extrinsic Q messages (total minus own R, saturated) with the hard decision.
module vnu_serial
    import vnu_pkg::*;
#(
    parameter int DV   = VNU_DV,
    parameter int W    = VNU_W,
    parameter int ACCW = W + $clog2(DV + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] llr_in,
    input  logic         r_valid,
    output logic         r_ready,
    input  logic [W-1:0] r_in,
    output logic         q_valid,
    input  logic         q_ready,
    output logic [W-1:0] q_out,
    output logic         q_last,
    output logic         p_out,
    output logic         busy
);

    localparam int IW = (DV > 1) ? $clog2(DV) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DV - 1);

    vnu_state_e             state_q, state_d;
    logic signed [ACCW-1:0] acc_q, acc_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic                   p_q, p_d;

    logic                   buf_we;
    logic [W-1:0]           buf_rdata;
    logic signed [ACCW-1:0] llr_ext, r_ext, acc_sum;
    logic signed [ACCW:0]   buf_ext, diff;
    logic signed [31:0]     q_sat;

    vnu_msg_buf #(
        .DV (DV),
        .W  (W),
        .IW (IW)
    ) u_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (idx_q),
        .wdata (r_in),
        .raddr (idx_q),
        .rdata (buf_rdata)
    );

    assign llr_ext = {{(ACCW - W){llr_in[W-1]}}, llr_in};
    assign r_ext   = {{(ACCW - W){r_in[W-1]}}, r_in};
    assign acc_sum = acc_q + r_ext;

    // One extra bit so total minus a full-scale R cannot wrap before clamping.
    assign buf_ext = {{(ACCW + 1 - W){buf_rdata[W-1]}}, buf_rdata};
    assign diff    = {acc_q[ACCW-1], acc_q} - buf_ext;
    assign q_sat   = sat_msg(32'(diff), W);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        p_d     = p_q;
        buf_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    acc_d   = llr_ext;
                    idx_d   = '0;
                    p_d     = 1'b0;
                end
            end
            LOAD: begin
                if (r_valid) begin
                    buf_we = 1'b1;
                    acc_d  = acc_sum;
                    idx_d  = idx_q + IW'(1);
                    if (idx_q == LAST_IDX) begin
                        state_d = EMIT;
                        idx_d   = '0;
                        p_d     = acc_sum[ACCW-1];
                    end
                end
            end
            EMIT: begin
                if (q_ready) begin
                    idx_d = idx_q + IW'(1);
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            idx_q   <= '0;
            p_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            p_q     <= p_d;
        end
    end

    // Q is derived from held registers, so it stays stable across a stall.
    assign r_ready = (state_q == LOAD);
    assign q_valid = (state_q == EMIT);
    assign q_out   = q_valid ? q_sat[W-1:0] : '0;
    assign q_last  = q_valid && (idx_q == LAST_IDX);
    assign p_out   = p_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_vnu_serial.sv
// Randomised scoreboard bench for vnu_serial: expected Q beats are queued
// from an integer model of the node update and popped by an output monitor.
module tb_vnu_serial;

    localparam int DV  = 6;
    localparam int W   = 8;
    localparam int LIM = 127;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] llr_in;
    logic         r_valid;
    logic         r_ready;
    logic [W-1:0] r_in;
    logic         q_valid;
    logic         q_ready;
    logic [W-1:0] q_out;
    logic         q_last;
    logic         p_out;
    logic         busy;

    vnu_serial #(.DV(DV), .W(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .llr_in  (llr_in),
        .r_valid (r_valid),
        .r_ready (r_ready),
        .r_in    (r_in),
        .q_valid (q_valid),
        .q_ready (q_ready),
        .q_out   (q_out),
        .q_last  (q_last),
        .p_out   (p_out),
        .busy    (busy)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    logic         exp_last_q[$];
    logic         exp_p_q[$];
    int           n_cmp = 0;
    int           n_err = 0;
    int           beat_cnt = 0;
    int           qr_mode = 0;
    int           stall_left = 0;
    int           r_vec[DV];
    int           last_p = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: total = L + sum(R); Q_i = clamp(total - R_i); p = total < 0.
    task automatic push_expected(input int l);
        int total;
        int q;
        total = l;
        for (int i = 0; i < DV; i++) total += r_vec[i];
        for (int i = 0; i < DV; i++) begin
            q = total - r_vec[i];
            if (q > LIM) q = LIM;
            if (q < -LIM) q = -LIM;
            exp_q.push_back(W'(q));
            exp_last_q.push_back(i == DV - 1);
            exp_p_q.push_back(total < 0);
        end
        last_p = (total < 0) ? 1 : 0;
    endtask

    // ---------------- monitor ----------------
    logic [W-1:0] held_q;
    logic         held_v = 1'b0;

    always @(negedge clk) begin
        logic [W-1:0] e;
        logic         el;
        logic         ep;
        if (reset) begin
            held_v   = 1'b0;
            beat_cnt = 0;
        end else begin
            if (held_v && q_valid) check("q_stable", int'($signed(q_out)), int'($signed(held_q)));
            held_v = q_valid && !q_ready;
            held_q = q_out;
            if (q_valid && q_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_q: got %0d expected no beat at %0t", $signed(q_out), $time);
                end else begin
                    e  = exp_q.pop_front();
                    el = exp_last_q.pop_front();
                    ep = exp_p_q.pop_front();
                    check("q_out", int'($signed(q_out)), int'($signed(e)));
                    check("q_last", int'(q_last), int'(el));
                    check("p_out", int'(p_out), int'(ep));
                end
                beat_cnt = q_last ? 0 : beat_cnt + 1;
            end
        end
    end

    // ---------------- q_ready driver ----------------
    always @(posedge clk) begin
        #1;
        case (qr_mode)
            0: q_ready = 1'b1;
            1: q_ready = 1'($urandom_range(0, 1));
            2: begin
                if (q_valid && beat_cnt == 1 && stall_left > 0) begin
                    q_ready = 1'b0;
                    stall_left--;
                end else begin
                    q_ready = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // ---------------- driver tasks ----------------
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_r(input int a, input int b, input int c, input int d, input int e, input int f);
        r_vec[0] = a; r_vec[1] = b; r_vec[2] = c;
        r_vec[3] = d; r_vec[4] = e; r_vec[5] = f;
    endtask

    function automatic int rnd_msg();
        logic [W-1:0] v;
        v = W'($urandom_range(0, 255));
        case ($urandom_range(0, 5))
            0: v = 8'h80;
            1: v = 8'h81;
            2: v = 8'h7f;
            default: ;
        endcase
        return int'($signed(v));
    endfunction

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 300) begin
            cycle();
            k++;
        end
        check("idle_reached", int'(busy), 0);
    endtask

    task automatic send_r(input bit gaps, input bit poke);
        int k;
        for (int i = 0; i < DV; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    r_valid = 1'b0;
                    cycle();
                end
            end
            r_valid = 1'b1;
            r_in    = W'(r_vec[i]);
            if (poke && i == 2) begin
                start  = 1'b1;
                llr_in = W'($urandom_range(0, 255));
            end
            k = 0;
            while (!r_ready && k < 50) begin
                cycle();
                k++;
            end
            if (!r_ready) check("r_ready_wait", int'(r_ready), 1);
            cycle();
            start = 1'b0;
        end
        r_valid = 1'b0;
    endtask

    task automatic run_node(input int l, input bit gaps, input int mode, input bit poke, input bit junk);
        int k;
        wait_idle();
        qr_mode    = mode;
        stall_left = 3;
        push_expected(l);
        start  = 1'b1;
        llr_in = W'(l);
        cycle();
        start = 1'b0;
        check("busy_after_start", int'(busy), 1);
        check("p_cleared_on_start", int'(p_out), 0);
        send_r(gaps, poke);
        if (poke && busy && !r_ready) begin
            start  = 1'b1;
            llr_in = W'($urandom_range(0, 255));
            cycle();
            start = 1'b0;
        end
        if (junk) begin
            k = 0;
            while (busy && k < 200) begin
                r_valid = 1'b1;
                r_in    = W'($urandom_range(0, 255));
                cycle();
                k++;
            end
            r_valid = 1'b0;
        end
        wait_idle();
        check("p_hold_idle", int'(p_out), last_p);
    endtask

    // start asserted in the very cycle of the final Q handshake must be ignored.
    task automatic run_last_hs_start(input int l);
        int  k;
        bit  hit;
        wait_idle();
        qr_mode = 3;
        q_ready = 1'b1;
        push_expected(l);
        start  = 1'b1;
        llr_in = W'(l);
        cycle();
        start = 1'b0;
        send_r(1'b0, 1'b0);
        hit = 1'b0;
        k   = 0;
        while (!hit && k < 50) begin
            if (q_valid && q_last) begin
                start  = 1'b1;
                llr_in = 8'h10;
                check("busy_in_last_hs", int'(busy), 1);
                cycle();
                start = 1'b0;
                hit   = 1'b1;
            end else begin
                cycle();
            end
            k++;
        end
        check("last_hs_seen", int'(hit), 1);
        check("busy_after_last_hs", int'(busy), 0);
        check("q_valid_after_last_hs", int'(q_valid), 0);
        repeat (3) cycle();
        check("start_on_last_hs_ignored", int'(busy), 0);
        qr_mode = 0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        llr_in  = '0;
        r_valid = 1'b0;
        r_in    = '0;
        q_ready = 1'b1;
        repeat (3) cycle();
        reset = 1'b0;
        cycle();
        check("rst_busy", int'(busy), 0);
        check("rst_q_valid", int'(q_valid), 0);
        check("rst_r_ready", int'(r_ready), 0);
        check("rst_p_out", int'(p_out), 0);
        check("rst_q_out", int'(q_out), 0);
        check("rst_q_last", int'(q_last), 0);

        set_r(-4, 10, 5, -6, 7, 8);
        run_node(4, 1'b0, 0, 1'b0, 1'b0);
        set_r(-4, 1, -11, -6, 7, 6);
        run_node(4, 1'b0, 0, 1'b0, 1'b0);
        set_r(127, 127, 127, 127, 127, 127);
        run_node(127, 1'b0, 0, 1'b0, 1'b0);
        set_r(-127, -127, -127, -127, -127, -127);
        run_node(-127, 1'b0, 0, 1'b0, 1'b0);
        set_r(0, 0, 0, 0, 0, 0);
        run_node(-128, 1'b0, 0, 1'b0, 1'b0);
        run_node(0, 1'b0, 0, 1'b0, 1'b0);

        set_r(-4, 10, 5, -6, 7, 8);
        run_node(4, 1'b1, 2, 1'b0, 1'b0);
        run_node(4, 1'b0, 0, 1'b1, 1'b0);
        run_node(4, 1'b1, 1, 1'b0, 1'b1);
        run_last_hs_start(4);

        // abort mid-LOAD after three beats, then rerun the same node cleanly
        set_r(-4, 1, -11, -6, 7, 6);
        run_node(4, 1'b0, 0, 1'b0, 1'b0);
        set_r(-4, 10, 5, -6, 7, 8);
        start  = 1'b1;
        llr_in = 8'd4;
        cycle();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            r_valid = 1'b1;
            r_in    = W'(r_vec[i]);
            cycle();
        end
        r_valid = 1'b0;
        reset   = 1'b1;
        cycle();
        check("abort_busy", int'(busy), 0);
        check("abort_q_valid", int'(q_valid), 0);
        check("abort_p_out", int'(p_out), 0);
        check("abort_r_ready", int'(r_ready), 0);
        reset = 1'b0;
        cycle();
        run_node(4, 1'b0, 0, 1'b0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < DV; i++) r_vec[i] = rnd_msg();
            run_node(rnd_msg(), 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        repeat (5) cycle();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
